truth_table_scanner: RTL and testbench

//  Sequential stimulus/capture engine that drives an N-input combinational boolean block through all 2^N input vectors.

---
 rtl/tt_pkg.sv | 15 +
 rtl/truth_table_scanner.sv | 112 +++++++++++
 tb/tb_truth_table_scanner.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_pkg.sv
// Shared types and size helper for the truth-table scanner.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } state_e;

  function automatic int unsigned TT_SIZE(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/truth_table_scanner.sv
// Clocked sweep of an N-input boolean block: drives every input vector, captures the
// 1-bit response into a truth mask, counts maxterms and compares against an expected mask.
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TT_SIZE(N)-1:0] expected,
  input  logic                  f_in,
  output logic [N-1:0]          vec_out,
  output logic                  busy,
  output logic                  done,
  output logic [TT_SIZE(N)-1:0] table_out,
  output logic [N:0]            zero_count,
  output logic                  mismatch,
  output logic [N-1:0]          first_bad_idx
);

  localparam int unsigned SZ = TT_SIZE(N);
  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N-1:0]  IDX_LAST = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);

  state_e          state_q;
  logic [SZ-1:0]   exp_q;
  logic [N-1:0]    idx_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    vec_q;
  logic            busy_q;
  logic            done_q;
  logic [SZ-1:0]   table_q;
  logic [N:0]      zc_q;
  logic            mm_q;
  logic [N-1:0]    fb_q;

  // Single-process FSM; every output is a register so vec_out never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      zc_q    <= '0;
      mm_q    <= 1'b0;
      fb_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q   <= expected;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            table_q <= '0;
            zc_q    <= '0;
            mm_q    <= 1'b0;
            fb_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_q <= SAMPLE;
        end
        SAMPLE: begin
          table_q[idx_q] <= f_in;
          if (!f_in) zc_q <= zc_q + (N+1)'(1);
          // Only the first disagreement is recorded, giving the lowest bad index.
          if ((f_in != exp_q[idx_q]) && !mm_q) begin
            mm_q <= 1'b1;
            fb_q <= idx_q;
          end
          if (idx_q == IDX_LAST) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + N'(1);
            vec_q   <= idx_q + N'(1);
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign table_out     = table_q;
  assign zero_count    = zc_q;
  assign mismatch      = mm_q;
  assign first_bad_idx = fb_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench for truth_table_scanner against a mask-level reference model.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;

  logic       start1, f1;
  logic [7:0] exp1, fmask1;
  logic [2:0] vec1, fb1;
  logic       busy1, done1, mm1;
  logic [7:0] tbl1;
  logic [3:0] zc1;

  logic       start3, f3;
  logic [7:0] exp3;
  logic [2:0] vec3, fb3;
  logic       busy3, done3, mm3;
  logic [7:0] tbl3;
  logic [3:0] zc3;

  logic [2:0] o_vec, o_fb;
  logic       o_busy, o_done, o_mm;
  logic [7:0] o_tbl;
  logic [3:0] o_zc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // PoS function (x+!y)(!x+z) when fmask1 holds its table, otherwise a random function.
  assign f1 = fmask1[vec1];
  assign f3 = 1'b1;

  truth_table_scanner #(.N(3), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .f_in(f1),
    .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tbl1),
    .zero_count(zc1), .mismatch(mm1), .first_bad_idx(fb1)
  );

  truth_table_scanner #(.N(3), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .expected(exp3), .f_in(f3),
    .vec_out(vec3), .busy(busy3), .done(done3), .table_out(tbl3),
    .zero_count(zc3), .mismatch(mm3), .first_bad_idx(fb3)
  );

  always_comb begin
    o_vec  = sel ? vec3  : vec1;
    o_busy = sel ? busy3 : busy1;
    o_done = sel ? done3 : done1;
    o_tbl  = sel ? tbl3  : tbl1;
    o_zc   = sel ? zc3   : zc1;
    o_mm   = sel ? mm3   : mm1;
    o_fb   = sel ? fb3   : fb1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic pos_f(input int v);
    logic x, y, z;
    x = v[2]; y = v[1]; z = v[0];
    return (x | ~y) & (~x | z);
  endfunction

  // Reference: captured table equals the function table; maxterms and first bad index from the diff.
  task automatic model(input logic [7:0] fm, input logic [7:0] em, output logic [7:0] t,
                       output logic [3:0] zc, output logic mm, output logic [2:0] fb);
    logic [7:0] diff;
    t    = fm;
    zc   = 4'(8 - $countones(fm));
    diff = fm ^ em;
    mm   = |diff;
    fb   = 3'd0;
    for (int i = 7; i >= 0; i--) if (diff[i]) fb = 3'(i);
  endtask

  task automatic check_results(input string tag, input logic [7:0] t, input logic [3:0] zc,
                               input logic mm, input logic [2:0] fb);
    chk({tag, "_table"}, 32'(o_tbl), 32'(t));
    chk({tag, "_zc"},    32'(o_zc),  32'(zc));
    chk({tag, "_mm"},    32'(o_mm),  32'(mm));
    chk({tag, "_fb"},    32'(o_fb),  32'(fb));
  endtask

  // Runs one scan; pulse_k > 0 re-asserts start and scrambles expected after that edge.
  task automatic do_scan(input bit use3, input logic [7:0] em, input int pulse_k, input bit chk_vec);
    int per, total;
    bit got_done;
    per = use3 ? 4 : 2;
    total = 8 * per;
    got_done = 1'b0;
    @(negedge clk);
    sel = use3;
    if (use3) begin start3 = 1'b1; exp3 = em; end
    else      begin start1 = 1'b1; exp1 = em; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    chk("busy_accept", 32'(o_busy), 32'd1);
    chk("vec_accept", 32'(o_vec), 32'd0);
    for (int k = 1; k <= total + 4 && !got_done; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == pulse_k) begin
        if (use3) begin start3 = 1'b1; exp3 = ~em; end
        else      begin start1 = 1'b1; exp1 = ~em; end
      end else begin
        start1 = 1'b0; start3 = 1'b0;
      end
      if (o_done) begin
        got_done = 1'b1;
        chk("done_edge", 32'(k), 32'(total));
        chk("busy_at_done", 32'(o_busy), 32'd0);
      end else if (chk_vec && k < total) begin
        chk("vec_step", 32'(o_vec), 32'(k / per));
      end
    end
    start1 = 1'b0; start3 = 1'b0;
    if (!got_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_pulse_len", 32'(o_done), 32'd0);
  endtask

  logic [7:0] t_m, pos_mask, em_r;
  logic [3:0] zc_m;
  logic       mm_m;
  logic [2:0] fb_m;
  bit         seen;

  initial begin
    rst = 1'b1; sel = 1'b0;
    start1 = 1'b0; start3 = 1'b0; exp1 = '0; exp3 = '0;
    for (int v = 0; v < 8; v++) pos_mask[v] = pos_f(v);
    fmask1 = pos_mask;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset / idle state
    chk("rst_vec", 32'(vec1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    check_results("rst", 8'h00, 4'd0, 1'b0, 3'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);
    chk("rst3_table", 32'(tbl3), 32'd0);

    // Pass case
    do_scan(1'b0, 8'hA3, 0, 1'b1);
    check_results("pass", 8'hA3, 4'd4, 1'b0, 3'd0);
    after_done();

    // Fail case, then results hold while idle
    do_scan(1'b0, 8'hA7, 0, 1'b0);
    check_results("fail", 8'hA3, 4'd4, 1'b1, 3'd2);
    after_done();
    repeat (5) @(negedge clk);
    check_results("hold", 8'hA3, 4'd4, 1'b1, 3'd2);
    chk("hold_busy", 32'(o_busy), 32'd0);

    // Start pulse and expected change mid-scan at vec 3
    do_scan(1'b0, 8'hA3, 6, 1'b1);
    check_results("midstart", 8'hA3, 4'd4, 1'b0, 3'd0);
    after_done();

    // Async reset at vec 5
    @(negedge clk);
    start1 = 1'b1; exp1 = 8'hA3;
    @(negedge clk);
    start1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (vec1 == 3'd5) seen = 1'b1;
    end
    chk("reach_vec5", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_vec", 32'(vec1), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    check_results("arst", 8'h00, 4'd0, 1'b0, 3'd0);
    #1 rst = 1'b0;
    do_scan(1'b0, 8'hA3, 0, 1'b1);
    check_results("post_rst", 8'hA3, 4'd4, 1'b0, 3'd0);
    after_done();

    // Start held high: next scan accepted right after the DONE cycle
    @(negedge clk);
    start1 = 1'b1; exp1 = 8'hA3;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    chk("held_done", 32'(seen), 32'd1);
    @(negedge clk);
    chk("held_idle_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("held_reaccept", 32'(busy1), 32'd1);
    start1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    chk("held_done2", 32'(seen), 32'd1);
    check_results("held", 8'hA3, 4'd4, 1'b0, 3'd0);
    after_done();

    // SETTLE_CYC=3, constant-1 function
    do_scan(1'b1, 8'h00, 0, 1'b1);
    check_results("s3", 8'hFF, 4'd0, 1'b1, 3'd0);
    after_done();
    sel = 1'b0;

    // Randomized functions, expected masks and mid-scan pulses
    for (int it = 0; it < 8; it++) begin
      fmask1 = 8'($urandom);
      em_r   = ($urandom_range(0, 3) == 0) ? fmask1 : 8'($urandom);
      model(fmask1, em_r, t_m, zc_m, mm_m, fb_m);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_scan(1'b0, em_r, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0, 1'b0);
      check_results("rand", t_m, zc_m, mm_m, fb_m);
      after_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
